// File: rtl/piece_queue_ctrl.sv
// piece_queue_ctrl: steps the piece RNG, filters out zero and immediate repeats,
// and keeps a small preview FIFO of upcoming tetromino IDs for the spawn logic.
module piece_queue_ctrl #(
   parameter int unsigned DEPTH  = 3,  // preview FIFO depth, 2..4
   parameter int unsigned REROLL = 1   // max rerolls on a repeated piece, 0 disables
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] rng_value,
   output logic       rng_step,
   input  logic       piece_req,
   output logic       piece_valid,
   output logic [2:0] piece_id,
   output logic [2:0] preview_id,
   output logic [2:0] fill_count
);

   localparam logic [2:0]   DepthW    = 3'(DEPTH);
   localparam int unsigned  RW        = (REROLL > 0) ? $clog2(REROLL + 1) : 1;
   localparam logic [RW-1:0] RerollMax = RW'(REROLL);

   typedef enum logic [1:0] {StIdle, StStep, StSample} state_t;

   state_t                 state;
   logic [2:0]             last_id;
   logic [RW-1:0]          reroll_cnt;
   // Entry 0 is the head; slots at or beyond fill_count are kept at zero.
   logic [DEPTH*3-1:0]     fifo;
   logic [DEPTH*3-1:0]     fifo_next;
   logic [2:0]             fill_next;
   logic [2:0]             wr_idx;
   logic                   pop;
   logic                   push;
   logic                   is_zero;
   logic                   is_repeat;
   logic                   accept;

   // Outputs decoded straight from the FIFO registers.
   assign piece_valid = (fill_count != 3'd0);
   assign piece_id    = fifo[2:0];
   assign preview_id  = fifo[5:3];

   // Sample decision and FIFO next-state: pop shifts toward the head, push lands at the tail.
   always_comb begin
      pop       = piece_req && (fill_count != 3'd0);
      is_zero   = (rng_value == 3'd0);
      is_repeat = (rng_value == last_id) && (reroll_cnt < RerollMax);
      accept    = (state == StSample) && !is_zero && !is_repeat;
      push      = accept && ((fill_count < DepthW) || pop);
      wr_idx    = pop ? (fill_count - 3'd1) : fill_count;

      fill_next = fill_count;
      if (push && !pop) begin
         fill_next = fill_count + 3'd1;
      end else if (pop && !push) begin
         fill_next = fill_count - 3'd1;
      end

      fifo_next = pop ? (fifo >> 3) : fifo;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (push && (wr_idx == 3'(i))) begin
            fifo_next[i*3 +: 3] = rng_value;
         end
      end
   end

   // FIFO storage and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo       <= '0;
         fill_count <= 3'd0;
      end else begin
         fifo       <= fifo_next;
         fill_count <= fill_next;
      end
   end

   // Generator sequencing FSM; rng_step is registered and high only while in StStep.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         rng_step   <= 1'b0;
         last_id    <= 3'd0;
         reroll_cnt <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (fill_count < DepthW) begin
                  state    <= StStep;
                  rng_step <= 1'b1;
               end
            end
            StStep: begin
               state    <= StSample;
               rng_step <= 1'b0;
            end
            StSample: begin
               if (is_zero) begin
                  state    <= StStep;
                  rng_step <= 1'b1;
               end else if (is_repeat) begin
                  reroll_cnt <= reroll_cnt + 1'b1;
                  state      <= StStep;
                  rng_step   <= 1'b1;
               end else begin
                  last_id    <= rng_value;
                  reroll_cnt <= '0;
                  if (fill_next < DepthW) begin
                     state    <= StStep;
                     rng_step <= 1'b1;
                  end else begin
                     state    <= StIdle;
                     rng_step <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= StIdle;
               rng_step <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Bench for piece_queue_ctrl: RNG model fed from a supply queue, a reference model of the
// accepted-piece stream, and a monitor that scoreboards every head piece the consumer takes.
module tb_piece_queue_ctrl;

   localparam int unsigned DEPTH  = 3;
   localparam int unsigned REROLL = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] rng_value;
   logic       rng_step;
   logic       piece_req;
   logic       piece_valid;
   logic [2:0] piece_id;
   logic [2:0] preview_id;
   logic [2:0] fill_count;

   int n_checks = 0;
   int n_fail   = 0;
   int step_cnt = 0;
   int pop_cnt  = 0;
   int supply[$];
   int exp_q[$];
   int m_last   = 0;
   int m_rr     = 0;
   bit pending  = 1'b0;

   piece_queue_ctrl #(.DEPTH(DEPTH), .REROLL(REROLL)) dut (
      .clk        (clk),
      .reset      (reset),
      .rng_value  (rng_value),
      .rng_step   (rng_step),
      .piece_req  (piece_req),
      .piece_valid(piece_valid),
      .piece_id   (piece_id),
      .preview_id (preview_id),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req_v);
      n_checks++;
      if (act != req_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
      end
   endtask

   // Reference rule for one generator value reaching the sampler.
   function automatic void model_take(input int v);
      if (v == 0) return;
      if (v == m_last && m_rr < int'(REROLL)) begin
         m_rr++;
         return;
      end
      exp_q.push_back(v);
      m_last = v;
      m_rr   = 0;
   endfunction

   function automatic int next_val();
      if (supply.size() > 0) return supply.pop_front();
      return int'($urandom_range(0, 7));
   endfunction

   // RNG model plus reference model: a stepped value is judged one cycle later.
   always @(posedge clk) begin
      if (reset) begin
         pending = 1'b0;
         m_last  = 0;
         m_rr    = 0;
         exp_q.delete();
         step_cnt = 0;
         rng_value <= 3'd0;
      end else begin
         if (pending) begin
            model_take(int'(rng_value));
            pending = 1'b0;
         end
         if (rng_step) begin
            rng_value <= 3'(next_val());
            pending  = 1'b1;
            step_cnt++;
         end
      end
   end

   // Monitor: invariants every cycle, scoreboard compare on every pop.
   always @(negedge clk) begin
      if (!reset) begin
         check("fill_le_depth", (int'(fill_count) <= int'(DEPTH)) ? 1 : 0, 1);
         check("valid_vs_fill", int'(piece_valid), (fill_count != 3'd0) ? 1 : 0);
         if (fill_count < 3'd2) check("preview_empty", int'(preview_id), 0);
         if (piece_req && piece_valid) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", int'(piece_id), -1);
            end else begin
               check("head_piece", int'(piece_id), exp_q.pop_front());
               if (fill_count >= 3'd2 && exp_q.size() > 0)
                  check("preview_piece", int'(preview_id), exp_q[0]);
               pop_cnt++;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench in cycle 1 after reset release.
   task automatic do_reset();
      reset = 1'b1;
      supply.delete();
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (!piece_valid && n < budget) begin
         tick();
         n++;
      end
      if (!piece_valid) check(name, 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      piece_req = 1'b0;

      // Reset values, latency, and fill to full with 3,5,2.
      do_reset();
      supply = '{3, 5, 2};
      check("rst_step", int'(rng_step), 0);
      check("rst_valid", int'(piece_valid), 0);
      check("rst_id", int'(piece_id), 0);
      check("rst_preview", int'(preview_id), 0);
      check("rst_fill", int'(fill_count), 0);
      tick();
      check("cyc2_step", int'(rng_step), 1);
      tick();
      check("cyc3_step", int'(rng_step), 0);
      check("cyc3_valid", int'(piece_valid), 0);
      tick();
      check("cyc4_valid", int'(piece_valid), 1);
      check("cyc4_id", int'(piece_id), 3);
      tick(20);
      check("full_steps", step_cnt, 3);
      check("full_fill", int'(fill_count), 3);
      check("full_id", int'(piece_id), 3);
      check("full_preview", int'(preview_id), 5);
      check("full_no_step", int'(rng_step), 0);

      // Pop one while full, next step supplies 7.
      supply.push_back(7);
      piece_req = 1'b1;
      tick();
      piece_req = 1'b0;
      tick(10);
      check("refill_id", int'(piece_id), 5);
      check("refill_preview", int'(preview_id), 2);
      check("refill_fill", int'(fill_count), 3);
      check("refill_steps", step_cnt, 4);
      piece_req = 1'b1;
      tick(2);
      piece_req = 1'b0;
      check("tail_id", int'(piece_id), 7);

      // Zero is rejected.
      do_reset();
      supply = '{0, 4, 1, 2};
      wait_valid("zero_wait", 20);
      check("zero_steps", step_cnt, 2);
      check("zero_id", int'(piece_id), 4);
      check("zero_fill", int'(fill_count), 1);

      // Repeat rerolled once, then allowed.
      do_reset();
      supply = '{6, 6, 6, 1};
      tick(30);
      check("rr_steps", step_cnt, 4);
      check("rr_id", int'(piece_id), 6);
      check("rr_preview", int'(preview_id), 6);
      check("rr_fill", int'(fill_count), 3);
      piece_req = 1'b1;
      tick(2);
      piece_req = 1'b0;
      check("rr_tail", int'(piece_id), 1);

      // Request held high through and after reset while empty.
      piece_req = 1'b1;
      do_reset();
      supply = '{2, 3, 4};
      check("req_empty_fill1", int'(fill_count), 0);
      tick(2);
      check("req_empty_fill3", int'(fill_count), 0);
      tick();
      check("req_first_valid", int'(piece_valid), 1);
      check("req_first_id", int'(piece_id), 2);
      tick();
      check("req_popped_fill", int'(fill_count), 0);
      piece_req = 1'b0;

      // Reset during SAMPLE with two entries.
      do_reset();
      supply = '{1, 2, 3};
      begin
         int n;
         n = 0;
         while (!(rng_step && fill_count == 3'd2) && n < 30) begin
            tick();
            n++;
         end
         check("mid_reset_reach", (rng_step && fill_count == 3'd2) ? 1 : 0, 1);
      end
      tick();
      reset = 1'b1;
      tick();
      check("mid_reset_fill", int'(fill_count), 0);
      check("mid_reset_valid", int'(piece_valid), 0);
      check("mid_reset_step", int'(rng_step), 0);
      check("mid_reset_id", int'(piece_id), 0);
      reset = 1'b0;
      tick();
      check("mid_restart_step", int'(rng_step), 1);

      // Random traffic against the reference model.
      do_reset();
      pop_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         piece_req = ($urandom_range(0, 99) < 40);
         if (c == 1500) reset = 1'b1;
         if (c == 1502) reset = 1'b0;
         tick();
      end
      piece_req = 1'b0;
      tick(2);
      check("random_pops_seen", (pop_cnt > 200) ? 1 : 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
